// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg
// Shared definitions for the pulse train generator: the controller state
// enumeration and the default counter width.
package pulse_gen_pkg;

    // Default width of the Period, Width and Pulse_Count fields and counters.
    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/pulse_train_gen_if.sv
// pulse_train_gen_if
// Control and output bundle of the pulse train generator.
//   Start       : one-cycle request to begin a train (sampled in IDLE only)
//   Stop        : abort request, effective in any state
//   Period      : cycles per pulse period
//   Width       : high cycles per period
//   Pulse_Count : number of periods in the train
//   Signal_Out  : registered pulse train
//   Busy        : high while a train is being generated
//   Done        : one-cycle pulse on normal completion
// master = requester side, slave = generator side.
interface pulse_train_gen_if
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

    logic             Start;
    logic             Stop;
    logic [CNT_W-1:0] Period;
    logic [CNT_W-1:0] Width;
    logic [CNT_W-1:0] Pulse_Count;
    logic             Signal_Out;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Stop, Period, Width, Pulse_Count,
        input  Signal_Out, Busy, Done
    );

    modport slave (
        input  Start, Stop, Period, Width, Pulse_Count,
        output Signal_Out, Busy, Done
    );

endinterface

// File: rtl/pulse_cycle_counter.sv
// pulse_cycle_counter
// CNT_W-bit up-counter that returns to 0 after reaching a terminal value.
//   clk_Signal : clock, rising edge
//   Rst        : asynchronous active-low reset
//   i_clr      : synchronous clear, overrides enable
//   i_en       : count enable
//   i_term     : terminal value; the count after i_term is 0
//   o_count    : current count
//   o_wrap     : high in the enabled cycle whose count equals i_term
module pulse_cycle_counter
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_Signal,
    input  logic             Rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_count;

    assign o_wrap  = i_en && (r_count == i_term);
    assign o_count = r_count;

    always_ff @(posedge clk_Signal or negedge Rst) begin
        if (!Rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_wrap ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen
// Generates Pulse_Count periods of Period cycles each; every period starts
// with min(Width, Period) high cycles. Parameters are latched on an accepted
// Start so later input changes do not disturb a running train.
//   clk_Signal : clock, rising edge
//   Rst        : asynchronous active-low reset
//   bus        : slave side of pulse_train_gen_if (Start/Stop/Period/Width/
//                Pulse_Count in; Signal_Out/Busy/Done out, all registered)
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic                     clk_Signal,
    input  logic                     Rst,
    pulse_train_gen_if.slave         bus
);

    state_e           r_state;
    state_e           w_state_next;

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_count;
    logic             w_load;

    logic             r_sig_out;
    logic             r_busy;
    logic             r_done;
    logic             w_sig_next;
    logic             w_busy_next;
    logic             w_done_next;

    logic             w_cnt_clr;
    logic             w_run;
    logic [CNT_W-1:0] w_phase_cnt;
    logic             w_phase_wrap;
    logic [CNT_W-1:0] w_phase_next;
    logic [CNT_W-1:0] w_period_cnt_unused;
    logic             w_period_wrap;

    assign w_run     = (r_state == RUN);
    // Counters only move in RUN; everywhere else they are held at zero so a
    // train always starts from phase 0, period 0.
    assign w_cnt_clr = !w_run || bus.Stop;

    pulse_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk_Signal (clk_Signal),
        .Rst        (Rst),
        .i_clr      (w_cnt_clr),
        .i_en       (w_run),
        .i_term     (r_period - CNT_W'(1)),
        .o_count    (w_phase_cnt),
        .o_wrap     (w_phase_wrap)
    );

    pulse_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_period_cnt (
        .clk_Signal (clk_Signal),
        .Rst        (Rst),
        .i_clr      (w_cnt_clr),
        .i_en       (w_phase_wrap),
        .i_term     (r_count - CNT_W'(1)),
        .o_count    (w_period_cnt_unused),
        .o_wrap     (w_period_wrap)
    );

    // Phase value of the next cycle; the output register is loaded with the
    // level for that phase so Signal_Out stays a pure flop.
    assign w_phase_next = w_phase_wrap ? '0 : w_phase_cnt + CNT_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_sig_next   = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.Start && !bus.Stop) begin
                    w_load = 1'b1;
                    if ((bus.Period != '0) && (bus.Pulse_Count != '0)) begin
                        w_state_next = RUN;
                        w_busy_next  = 1'b1;
                        w_sig_next   = (bus.Width != '0);
                    end else begin
                        w_state_next = FIN;
                        w_done_next  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.Stop) begin
                    w_state_next = IDLE;
                end else if (w_period_wrap) begin
                    w_state_next = FIN;
                    w_done_next  = 1'b1;
                end else begin
                    w_busy_next = 1'b1;
                    // Phase is always < Period here, so this is p < min(W, P).
                    w_sig_next  = (w_phase_next < r_width);
                end
            end
            FIN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_Signal or negedge Rst) begin
        if (!Rst) begin
            r_state   <= IDLE;
            r_sig_out <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sig_out <= w_sig_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    always_ff @(posedge clk_Signal or negedge Rst) begin
        if (!Rst) begin
            r_period <= '0;
            r_width  <= '0;
            r_count  <= '0;
        end else if (w_load) begin
            r_period <= bus.Period;
            r_width  <= bus.Width;
            r_count  <= bus.Pulse_Count;
        end
    end

    assign bus.Signal_Out = r_sig_out;
    assign bus.Busy       = r_busy;
    assign bus.Done       = r_done;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen
// Directed self-checking bench for pulse_train_gen. Inputs change and outputs
// are sampled on the falling clock edge; cycle c counts falling edges after
// the rising edge that accepted Start (c=1 is cycle t+1).
module tb_pulse_train_gen;

    logic clk_Signal;
    logic Rst;
    int   n_checks;
    int   n_fail;

    pulse_train_gen_if #(.CNT_W(8)) bus ();

    pulse_train_gen #(
        .CNT_W (8)
    ) dut (
        .clk_Signal (clk_Signal),
        .Rst        (Rst),
        .bus        (bus)
    );

    initial clk_Signal = 1'b0;
    always #5 clk_Signal = ~clk_Signal;

    // Present Start for one cycle; returns at the falling edge of cycle t+1.
    task automatic pulse_start(input logic [7:0] p, input logic [7:0] w, input logic [7:0] n);
        bus.Start       = 1'b1;
        bus.Period      = p;
        bus.Width       = w;
        bus.Pulse_Count = n;
        @(negedge clk_Signal);
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({bus.Signal_Out, bus.Busy, bus.Done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=000", {bus.Signal_Out, bus.Busy, bus.Done});
        end
        @(negedge clk_Signal);
        Rst = 1'b1;
        @(negedge clk_Signal);
        n_checks++;
        if ({bus.Signal_Out, bus.Busy, bus.Done} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%b exp=000",
                     {bus.Signal_Out, bus.Busy, bus.Done});
        end
    endtask

    // P=5 W=2 N=3: high at 1,2,6,7,11,12; Busy 1..15; Done at 16.
    task automatic test_basic();
        logic es, eb, ed;
        pulse_start(8'd5, 8'd2, 8'd3);
        for (int c = 1; c <= 18; c++) begin
            es = (c inside {1, 2, 6, 7, 11, 12});
            eb = (c >= 1 && c <= 15);
            ed = (c == 16);
            n_checks += 3;
            if (bus.Signal_Out !== es) begin
                n_fail++;
                $display("FAIL basic_sig c=%0d got=%b exp=%b", c, bus.Signal_Out, es);
            end
            if (bus.Busy !== eb) begin
                n_fail++;
                $display("FAIL basic_busy c=%0d got=%b exp=%b", c, bus.Busy, eb);
            end
            if (bus.Done !== ed) begin
                n_fail++;
                $display("FAIL basic_done c=%0d got=%b exp=%b", c, bus.Done, ed);
            end
            @(negedge clk_Signal);
        end
    endtask

    // P=4 W=9 N=2: high 1..8 with Done at 9; then P=3 W=0 N=2: never high,
    // Busy 1..6, Done at 7.
    task automatic test_width_bounds();
        logic es, eb, ed;
        pulse_start(8'd4, 8'd9, 8'd2);
        for (int c = 1; c <= 10; c++) begin
            es = (c <= 8);
            eb = (c <= 8);
            ed = (c == 9);
            n_checks += 3;
            if (bus.Signal_Out !== es) begin
                n_fail++;
                $display("FAIL wide_sig c=%0d got=%b exp=%b", c, bus.Signal_Out, es);
            end
            if (bus.Busy !== eb) begin
                n_fail++;
                $display("FAIL wide_busy c=%0d got=%b exp=%b", c, bus.Busy, eb);
            end
            if (bus.Done !== ed) begin
                n_fail++;
                $display("FAIL wide_done c=%0d got=%b exp=%b", c, bus.Done, ed);
            end
            @(negedge clk_Signal);
        end
        pulse_start(8'd3, 8'd0, 8'd2);
        for (int c = 1; c <= 8; c++) begin
            eb = (c <= 6);
            ed = (c == 7);
            n_checks += 3;
            if (bus.Signal_Out !== 1'b0) begin
                n_fail++;
                $display("FAIL w0_sig c=%0d got=%b exp=0", c, bus.Signal_Out);
            end
            if (bus.Busy !== eb) begin
                n_fail++;
                $display("FAIL w0_busy c=%0d got=%b exp=%b", c, bus.Busy, eb);
            end
            if (bus.Done !== ed) begin
                n_fail++;
                $display("FAIL w0_done c=%0d got=%b exp=%b", c, bus.Done, ed);
            end
            @(negedge clk_Signal);
        end
    endtask

    // Pulse_Count=0, then Period=0: no output, no Busy, Done at 1 only.
    task automatic test_zero();
        logic [7:0] pv[2] = '{8'd5, 8'd0};
        logic [7:0] nv[2] = '{8'd0, 8'd3};
        for (int v = 0; v < 2; v++) begin
            pulse_start(pv[v], 8'd2, nv[v]);
            for (int c = 1; c <= 3; c++) begin
                n_checks += 2;
                if ({bus.Signal_Out, bus.Busy} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL zero_out v=%0d c=%0d got=%b exp=00", v, c,
                             {bus.Signal_Out, bus.Busy});
                end
                if (bus.Done !== (c == 1)) begin
                    n_fail++;
                    $display("FAIL zero_done v=%0d c=%0d got=%b exp=%b", v, c, bus.Done, c == 1);
                end
                @(negedge clk_Signal);
            end
        end
    endtask

    // P=6 W=3 N=4, Stop during cycle 8: cleared at 9, no Done, new Start at 9
    // (P=2 W=1 N=1) runs normally.
    task automatic test_stop();
        logic es;
        pulse_start(8'd6, 8'd3, 8'd4);
        for (int c = 1; c <= 8; c++) begin
            es = (c inside {1, 2, 3, 7, 8});
            n_checks += 3;
            if (bus.Signal_Out !== es) begin
                n_fail++;
                $display("FAIL stop_sig c=%0d got=%b exp=%b", c, bus.Signal_Out, es);
            end
            if (bus.Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_busy c=%0d got=%b exp=1", c, bus.Busy);
            end
            if (bus.Done !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_done c=%0d got=%b exp=0", c, bus.Done);
            end
            if (c == 8) bus.Stop = 1'b1;
            @(negedge clk_Signal);
        end
        bus.Stop = 1'b0;
        n_checks++;
        if ({bus.Signal_Out, bus.Busy, bus.Done} !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_cleared got=%b exp=000", {bus.Signal_Out, bus.Busy, bus.Done});
        end
        pulse_start(8'd2, 8'd1, 8'd1);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if ({bus.Signal_Out, bus.Busy, bus.Done} !== {c == 1, c <= 2, c == 3}) begin
                n_fail++;
                $display("FAIL stop_restart c=%0d got=%b exp=%b", c,
                         {bus.Signal_Out, bus.Busy, bus.Done}, {c == 1, c <= 2, c == 3});
            end
            @(negedge clk_Signal);
        end
    endtask

    // Second Start and changed inputs mid-train are ignored; Start+Stop in
    // IDLE starts nothing.
    task automatic test_ignore_start();
        logic es, eb, ed;
        pulse_start(8'd3, 8'd1, 8'd2);
        for (int c = 1; c <= 8; c++) begin
            es = (c inside {1, 4});
            eb = (c <= 6);
            ed = (c == 7);
            n_checks += 3;
            if (bus.Signal_Out !== es) begin
                n_fail++;
                $display("FAIL ign_sig c=%0d got=%b exp=%b", c, bus.Signal_Out, es);
            end
            if (bus.Busy !== eb) begin
                n_fail++;
                $display("FAIL ign_busy c=%0d got=%b exp=%b", c, bus.Busy, eb);
            end
            if (bus.Done !== ed) begin
                n_fail++;
                $display("FAIL ign_done c=%0d got=%b exp=%b", c, bus.Done, ed);
            end
            bus.Start = (c == 2);
            if (c == 2) begin
                bus.Period      = 8'd7;
                bus.Width       = 8'd7;
                bus.Pulse_Count = 8'd9;
            end
            @(negedge clk_Signal);
        end
        bus.Start       = 1'b1;
        bus.Stop        = 1'b1;
        bus.Period      = 8'd3;
        bus.Pulse_Count = 8'd2;
        @(negedge clk_Signal);
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if ({bus.Signal_Out, bus.Busy, bus.Done} !== 3'b000) begin
                n_fail++;
                $display("FAIL start_stop_idle c=%0d got=%b exp=000", c,
                         {bus.Signal_Out, bus.Busy, bus.Done});
            end
            @(negedge clk_Signal);
        end
    endtask

    // Start held through FIN is ignored there and accepted in the next IDLE.
    task automatic test_back_to_back();
        pulse_start(8'd2, 8'd1, 8'd1);
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if ({bus.Signal_Out, bus.Busy, bus.Done} !== {c == 1, c <= 2, c == 3}) begin
                n_fail++;
                $display("FAIL b2b_first c=%0d got=%b exp=%b", c,
                         {bus.Signal_Out, bus.Busy, bus.Done}, {c == 1, c <= 2, c == 3});
            end
            if (c < 3) @(negedge clk_Signal);
        end
        bus.Start = 1'b1;
        @(negedge clk_Signal);
        n_checks++;
        if ({bus.Signal_Out, bus.Busy, bus.Done} !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_fin_ignored got=%b exp=000", {bus.Signal_Out, bus.Busy, bus.Done});
        end
        pulse_start(8'd2, 8'd1, 8'd1);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if ({bus.Signal_Out, bus.Busy, bus.Done} !== {c == 1, c <= 2, c == 3}) begin
                n_fail++;
                $display("FAIL b2b_second c=%0d got=%b exp=%b", c,
                         {bus.Signal_Out, bus.Busy, bus.Done}, {c == 1, c <= 2, c == 3});
            end
            @(negedge clk_Signal);
        end
    endtask

    // Rst low at t+3 clears outputs without a clock edge; after release a
    // P=1 W=1 N=2 train gives two high cycles then Done.
    task automatic test_reset_mid();
        pulse_start(8'd5, 8'd5, 8'd3);
        repeat (2) @(negedge clk_Signal);
        n_checks++;
        if ({bus.Signal_Out, bus.Busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL rmid_running got=%b exp=11", {bus.Signal_Out, bus.Busy});
        end
        #2 Rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.Signal_Out, bus.Busy, bus.Done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rmid_async got=%b exp=000", {bus.Signal_Out, bus.Busy, bus.Done});
        end
        @(negedge clk_Signal);
        Rst = 1'b1;
        pulse_start(8'd1, 8'd1, 8'd2);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if ({bus.Signal_Out, bus.Busy, bus.Done} !== {c <= 2, c <= 2, c == 3}) begin
                n_fail++;
                $display("FAIL rmid_restart c=%0d got=%b exp=%b", c,
                         {bus.Signal_Out, bus.Busy, bus.Done}, {c <= 2, c <= 2, c == 3});
            end
            @(negedge clk_Signal);
        end
    endtask

    // Full-range fields: P=255 W=254 N=1 and P=1 W=1 N=255.
    task automatic test_max_values();
        pulse_start(8'd255, 8'd254, 8'd1);
        for (int c = 1; c <= 257; c++) begin
            n_checks++;
            if ({bus.Signal_Out, bus.Busy, bus.Done} !== {c <= 254, c <= 255, c == 256}) begin
                n_fail++;
                $display("FAIL max_period c=%0d got=%b exp=%b", c,
                         {bus.Signal_Out, bus.Busy, bus.Done}, {c <= 254, c <= 255, c == 256});
            end
            @(negedge clk_Signal);
        end
        pulse_start(8'd1, 8'd1, 8'd255);
        for (int c = 1; c <= 257; c++) begin
            n_checks++;
            if ({bus.Signal_Out, bus.Busy, bus.Done} !== {c <= 255, c <= 255, c == 256}) begin
                n_fail++;
                $display("FAIL max_count c=%0d got=%b exp=%b", c,
                         {bus.Signal_Out, bus.Busy, bus.Done}, {c <= 255, c <= 255, c == 256});
            end
            @(negedge clk_Signal);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        Rst             = 1'b0;
        bus.Start       = 1'b0;
        bus.Stop        = 1'b0;
        bus.Period      = '0;
        bus.Width       = '0;
        bus.Pulse_Count = '0;
        test_reset();
        test_basic();
        test_width_bounds();
        test_zero();
        test_stop();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_max_values();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
